// File: rtl/viterbi_ber_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_ber_sequencer
// Description : Test-frame controller for an encoder -> channel -> Viterbi
//               chain. Emits an LFSR payload plus zero tail and schedules burst
//               error masks. Counts decoded payload bit errors against a
//               latency-aligned reference copy of the payload.
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_ber_sequencer #(
  parameter int FRAME_LEN = 256,
  parameter int TAIL_LEN  = 8,
  parameter int DEC_LAT   = 70,
  parameter int N         = 5,
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        inj_en_i,
  input  logic [15:0] seed_i,
  input  logic        dec_bit_i,
  output logic        enc_bit_o,
  output logic        enc_en_o,
  output logic [1:0]  err_mask_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] bit_err_ct_o,
  output logic [15:0] inj_ct_o,
  output logic        frame_pass_o
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_RUN   = 3'd1;
  localparam logic [2:0] c_TAIL  = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_nstate;
  logic [15:0]        r_cnt;
  logic [15:0]        r_lfsr;
  logic [15:0]        w_lfsr_nxt;
  logic [15:0]        w_seed;
  logic               w_start;
  logic               r_inj_en;
  logic               w_inj_act;
  logic               w_trig;
  logic [3:0]         r_burst;
  logic [3:0]         w_burst_eff;
  logic [3:0]         w_burst_nxt;
  logic [1:0]         w_mask_nxt;
  logic               r_enc_bit;
  logic               r_enc_en;
  logic [1:0]         r_err_mask;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic [15:0]        r_bit_err_ct;
  logic [15:0]        r_inj_ct;
  logic [15:0]        w_bit_err_nxt;
  logic [15:0]        w_inj_nxt;
  logic               w_cmp_err;
  logic [DEC_LAT-1:0] r_dl_flag;
  logic [DEC_LAT-1:0] r_dl_bit;

  assign w_start = (r_state == c_IDLE) && start_i;
  // An all-zero seed would lock the LFSR, so it maps to the default seed.
  assign w_seed  = (seed_i == 16'h0000) ? 16'hACE1 : seed_i;

  // Phase sequencing: each phase ends when its cycle counter hits length-1.
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      c_IDLE:  if (start_i) w_nstate = c_RUN;
      c_RUN:   if (r_cnt == 16'(FRAME_LEN - 1)) w_nstate = c_TAIL;
      c_TAIL:  if (r_cnt == 16'(TAIL_LEN - 1)) w_nstate = c_DRAIN;
      c_DRAIN: if (r_cnt == 16'(DEC_LAT - 1)) w_nstate = c_DONE;
      c_DONE:  w_nstate = c_IDLE;
      default: w_nstate = c_IDLE;
    endcase
  end

  // LFSR value for the upcoming cycle: loaded at start, shifted per RUN/TAIL cycle.
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (w_start) begin
      w_lfsr_nxt = w_seed;
    end else if (r_state == c_RUN || r_state == c_TAIL) begin
      w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
  end

  // Burst scheduling is judged on the LFSR value of the cycle being masked,
  // so the triggering cycle itself is the first masked cycle of the burst.
  assign w_inj_act = (w_start ? inj_en_i : r_inj_en) &&
                     (w_nstate == c_RUN || w_nstate == c_TAIL);
  assign w_trig    = &w_lfsr_nxt[N+1:2];

  // Burst counter and mask for the upcoming cycle; leaving TAIL truncates a burst.
  always_comb begin
    w_burst_eff = r_burst;
    w_burst_nxt = 4'd0;
    w_mask_nxt  = 2'b00;
    if (r_burst == 4'd0 && w_trig) w_burst_eff = 4'(BURST_LEN);
    if (w_inj_act && w_burst_eff != 4'd0) begin
      w_mask_nxt  = w_lfsr_nxt[15:14];
      w_burst_nxt = w_burst_eff - 4'd1;
    end
  end

  assign w_cmp_err = r_dl_flag[DEC_LAT-1] && (dec_bit_i != r_dl_bit[DEC_LAT-1]);

  // Saturating frame counters; start clears them, the first masked cycle may coincide.
  always_comb begin
    w_bit_err_nxt = r_bit_err_ct;
    w_inj_nxt     = r_inj_ct;
    if (w_start) begin
      w_bit_err_nxt = 16'h0000;
      w_inj_nxt     = (w_mask_nxt != 2'b00) ? 16'h0001 : 16'h0000;
    end else begin
      if (w_cmp_err && r_bit_err_ct != 16'hFFFF) w_bit_err_nxt = r_bit_err_ct + 16'h0001;
      if (w_mask_nxt != 2'b00 && r_inj_ct != 16'hFFFF) w_inj_nxt = r_inj_ct + 16'h0001;
    end
  end

  // Main state, LFSR, registered outputs and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_IDLE;
      r_cnt        <= 16'h0000;
      r_lfsr       <= 16'hACE1;
      r_inj_en     <= 1'b0;
      r_burst      <= 4'd0;
      r_enc_bit    <= 1'b0;
      r_enc_en     <= 1'b0;
      r_err_mask   <= 2'b00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_bit_err_ct <= 16'h0000;
      r_inj_ct     <= 16'h0000;
    end else begin
      r_state      <= w_nstate;
      r_cnt        <= (w_nstate != r_state || r_state == c_IDLE) ? 16'h0000 : r_cnt + 16'h0001;
      r_lfsr       <= w_lfsr_nxt;
      if (w_start) r_inj_en <= inj_en_i;
      r_burst      <= w_burst_nxt;
      r_enc_en     <= (w_nstate == c_RUN) || (w_nstate == c_TAIL);
      r_enc_bit    <= (w_nstate == c_RUN) && w_lfsr_nxt[0];
      r_err_mask   <= w_mask_nxt;
      r_busy       <= (w_nstate != c_IDLE);
      r_done       <= (w_nstate == c_DONE);
      r_bit_err_ct <= w_bit_err_nxt;
      r_inj_ct     <= w_inj_nxt;
      if (w_start) begin
        r_pass <= 1'b0;
      end else if (w_nstate == c_DONE) begin
        r_pass <= (w_bit_err_nxt == 16'h0000);
      end
    end
  end

  // Reference delay line: {payload flag, bit} as driven to the encoder each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dl_flag <= '0;
      r_dl_bit  <= '0;
    end else begin
      r_dl_flag <= DEC_LAT'({r_dl_flag, (r_state == c_RUN)});
      r_dl_bit  <= DEC_LAT'({r_dl_bit, r_enc_bit});
    end
  end

  assign enc_bit_o    = r_enc_bit;
  assign enc_en_o     = r_enc_en;
  assign err_mask_o   = r_err_mask;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign bit_err_ct_o = r_bit_err_ct;
  assign inj_ct_o     = r_inj_ct;
  assign frame_pass_o = r_pass;

endmodule
`default_nettype wire

// File: doc/viterbi_ber_sequencer.md
Name: viterbi_ber_sequencer

Overview:
- Test-frame controller for the convolutional encoder -> channel -> Viterbi decoder chain.
- Generates a pseudo-random payload frame plus zero tail and drives the encoder enable.
- Schedules burst error-injection masks for the channel register.
- Compares decoder output against a latency-aligned copy of the payload and reports bit-error and injection counts per frame.

Parameters:
- FRAME_LEN, 256, payload bits per frame (2..4096).
- TAIL_LEN, 8, zero flush bits appended after payload (>= encoder memory).
- DEC_LAT, 70, cycles from enc_en_o high to the matching dec_bit_i (1..255).
- N, 5, injection trigger width; average trigger rate is 1 in 2**N payload/tail cycles.
- BURST_LEN, 4, consecutive masked cycles per trigger (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  one-cycle pulse; begins a frame when idle
- inj_en_i  in  1  enables error injection for the frame (sampled at start)
- seed_i  in  16  LFSR seed (sampled at start)
- dec_bit_i  in  1  decoder output bit
- enc_bit_o  out  1  payload/tail bit to encoder
- enc_en_o  out  1  encoder enable
- err_mask_o  out  2  XOR mask for the channel symbol produced this cycle
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse, counts final
- bit_err_ct_o  out  16  decoded payload bit errors in current/last frame
- inj_ct_o  out  16  cycles with nonzero err_mask_o in current/last frame
- frame_pass_o  out  1  bit_err_ct_o==0, valid while done_o high and held until the next start

Behaviour:
- Reset (synchronous, rst=1 at posedge): state IDLE; all outputs 0; LFSR = 16'hACE1; delay line cleared; burst counter 0. Reset mid-frame aborts immediately, with no done_o pulse.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts once per RUN/TAIL cycle. Seed 0 is replaced by 16'hACE1.
- FSM:
  - IDLE: on start_i, load LFSR, latch inj_en_i, clear counters, set busy_o=1, go to RUN. start_i while not IDLE is ignored.
  - RUN: FRAME_LEN cycles; enc_en_o=1; enc_bit_o=lfsr[0]. Bit counter 0..FRAME_LEN-1, then go to TAIL.
  - TAIL: TAIL_LEN cycles; enc_en_o=1; enc_bit_o=0; then go to DRAIN.
  - DRAIN: DEC_LAT cycles; enc_en_o=0; then go to DONE.
  - DONE: done_o=1 for one cycle; busy_o=0 on the next cycle; return to IDLE.
- Outputs are registered: enc_en_o, enc_bit_o and err_mask_o change on the clock edge entering/within each state.
- Reference delay line: DEC_LAT-stage shift register of {payload_flag, bit}, shifted every cycle. payload_flag=1 only for RUN cycles.
- Compare: when the delay line output has payload_flag=1 and dec_bit_i != ref bit, bit_err_ct_o increments. Tail bits are never compared.
- Injection, active only if the latched inj_en=1 and state is RUN or TAIL:
  - Trigger when lfsr[N+1:2] is all ones and burst counter is 0; this loads burst counter = BURST_LEN.
  - While burst counter > 0: err_mask_o = lfsr[15:14] and the counter decrements. Otherwise err_mask_o = 0.
  - A retrigger during a burst is ignored.
  - A burst still active on exit from TAIL is truncated; err_mask_o = 0 in DRAIN.
- inj_ct_o increments on each cycle with err_mask_o != 0. A mask of 2'b00 inside a burst is not counted.
- Counters saturate at 16'hFFFF.
- If bit-error and end-of-DRAIN events fall in the same cycle, the final compare is included before done_o.
- Frame period = FRAME_LEN+TAIL_LEN+DEC_LAT+1 cycles, plus 1 IDLE cycle minimum between frames.

Test Plan:
- Clean loop: inj_en_i=0, seed 16'h1234, decoder model = ideal DEC_LAT delay of enc_bit_o -> done_o at cycle 256+8+70+1 after start, bit_err_ct_o=0, inj_ct_o=0, frame_pass_o=1.
- Forced mismatch: ideal decoder with dec_bit_i inverted on exactly 3 payload compare cycles and 2 tail-aligned cycles -> bit_err_ct_o=3, frame_pass_o=0.
- Injection: inj_en_i=1, N=1, BURST_LEN=4 -> err_mask_o nonzero only during RUN/TAIL, bursts ≤4 cycles, inj_ct_o equals the scoreboard count of nonzero masks, err_mask_o=0 throughout DRAIN.
- Seed zero: seed_i=0 -> enc_bit_o sequence identical to the sequence for seed 16'hACE1.
- start_i pulsed mid-RUN -> ignored, frame length unchanged. Then rst=1 for one cycle mid-TAIL -> all outputs 0 next cycle, no done_o pulse, a new start runs a full frame.
- Saturation: FRAME_LEN=4096 across repeated frames, dec_bit_i forced to the inverse of the reference -> bit_err_ct_o=4096 per frame. With counter preloaded near max via a force, it holds at 16'hFFFF.
